// File: rtl/pred_update_sched_if.sv
// Commit-side retire slots in, predictor update port and statistics out.
// The master drives the two commit slots; the slave is the update scheduler.
interface pred_update_sched_if;
  logic        cmt_valid_0;
  logic [31:0] cmt_pc_0;
  logic [2:0]  cmt_type_0;
  logic        cmt_cond_0;
  logic        cmt_taken_0;
  logic        cmt_mispred_0;
  logic [31:0] cmt_target_0;
  logic        cmt_valid_1;
  logic [31:0] cmt_pc_1;
  logic [2:0]  cmt_type_1;
  logic        cmt_cond_1;
  logic        cmt_taken_1;
  logic        cmt_mispred_1;
  logic [31:0] cmt_target_1;
  logic        cmt_ready;
  logic        update_orien_en;
  logic [31:0] retire_pc;
  logic        right_orien;
  logic        branch_mistaken;
  logic [31:0] wrong_pc;
  logic [31:0] right_target;
  logic [2:0]  ins_type_w;
  logic [31:0] cnt_branch;
  logic [31:0] cnt_mispred;

  modport master (
    output cmt_valid_0, cmt_pc_0, cmt_type_0, cmt_cond_0, cmt_taken_0, cmt_mispred_0, cmt_target_0,
    output cmt_valid_1, cmt_pc_1, cmt_type_1, cmt_cond_1, cmt_taken_1, cmt_mispred_1, cmt_target_1,
    input  cmt_ready,
    input  update_orien_en, retire_pc, right_orien,
    input  branch_mistaken, wrong_pc, right_target, ins_type_w,
    input  cnt_branch, cnt_mispred
  );

  modport slave (
    input  cmt_valid_0, cmt_pc_0, cmt_type_0, cmt_cond_0, cmt_taken_0, cmt_mispred_0, cmt_target_0,
    input  cmt_valid_1, cmt_pc_1, cmt_type_1, cmt_cond_1, cmt_taken_1, cmt_mispred_1, cmt_target_1,
    output cmt_ready,
    output update_orien_en, retire_pc, right_orien,
    output branch_mistaken, wrong_pc, right_target, ins_type_w,
    output cnt_branch, cnt_mispred
  );
endinterface

// File: rtl/pred_update_sched.sv
// Buffers up to two retiring branches per cycle and drains one per cycle to the predictor; an entry
// is presented the cycle after enqueue. cmt_ready drops once fewer than two free slots remain.
module pred_update_sched #(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  pred_update_sched_if.slave bus
);
  localparam int PTRW = $clog2(DEPTH);
  localparam logic [PTRW:0] READY_MAX = (PTRW + 1)'(DEPTH - 2);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [2:0]  typ;
    logic        cond;
    logic        taken;
    logic        mispred;
  } entry_t;

  function automatic logic wants_update(input logic [2:0] typ, input logic cond, input logic mispred);
    return (typ != 3'b000) || cond || mispred;
  endfunction

  entry_t ram [DEPTH];

  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW:0]   count_q, count_d;
  logic [31:0]     cnt_branch_q, cnt_branch_d;
  logic [31:0]     cnt_mispred_q, cnt_mispred_d;

  entry_t          slot0_dat, slot1_dat, head_dat, out_dat;
  logic            ready, wr0, wr1, deq;
  logic [1:0]      enq_n;
  logic [PTRW-1:0] wr1_idx;

  always_comb begin
    slot0_dat = '{pc: bus.cmt_pc_0, target: bus.cmt_target_0, typ: bus.cmt_type_0,
                  cond: bus.cmt_cond_0, taken: bus.cmt_taken_0, mispred: bus.cmt_mispred_0};
    slot1_dat = '{pc: bus.cmt_pc_1, target: bus.cmt_target_1, typ: bus.cmt_type_1,
                  cond: bus.cmt_cond_1, taken: bus.cmt_taken_1, mispred: bus.cmt_mispred_1};

    // Ready looks only at registered occupancy so commit never sees a combinational path.
    ready   = (count_q <= READY_MAX);
    wr0     = bus.cmt_valid_0 && ready && wants_update(bus.cmt_type_0, bus.cmt_cond_0, bus.cmt_mispred_0);
    wr1     = bus.cmt_valid_1 && ready && wants_update(bus.cmt_type_1, bus.cmt_cond_1, bus.cmt_mispred_1);
    enq_n   = {1'b0, wr0} + {1'b0, wr1};
    wr1_idx = wr_ptr_q + PTRW'(wr0);

    deq      = (count_q != '0);
    head_dat = ram[rd_ptr_q];
    out_dat  = deq ? head_dat : '0;

    rd_ptr_d = rd_ptr_q + PTRW'(deq);
    wr_ptr_d = wr_ptr_q + PTRW'(enq_n);
    count_d  = count_q + (PTRW + 1)'(enq_n) - (PTRW + 1)'(deq);

    cnt_branch_d  = cnt_branch_q + {31'd0, deq && ((head_dat.typ != 3'b000) || head_dat.cond)};
    cnt_mispred_d = cnt_mispred_q + {31'd0, deq && head_dat.mispred};
  end

  // Payload storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr0) ram[wr_ptr_q] <= slot0_dat;
    if (wr1) ram[wr1_idx]  <= slot1_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      cnt_branch_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      assert (int'(count_q) + int'(enq_n) - int'(deq) <= DEPTH);
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      cnt_branch_q  <= cnt_branch_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign bus.cmt_ready       = ready;
  assign bus.update_orien_en = deq && out_dat.cond;
  assign bus.retire_pc       = out_dat.pc;
  assign bus.right_orien     = out_dat.taken;
  assign bus.branch_mistaken = deq && out_dat.mispred;
  assign bus.wrong_pc        = out_dat.pc;
  assign bus.right_target    = out_dat.target;
  assign bus.ins_type_w      = out_dat.typ;
  assign bus.cnt_branch      = cnt_branch_q;
  assign bus.cnt_mispred     = cnt_mispred_q;
endmodule
